// File: rtl/seg7_mux_ctrl_pkg.sv
// Shared constants for the multiplexed seven-segment display controller:
// active-low segment codes for hex digits, the blank pattern and the dp bit.
package seg7_mux_ctrl_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam int         DP_BIT  = 7;

  // Index is the hex nibble; bit7 (dp) is left off in every entry.
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] seg_lookup(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_mux_ctrl_decode.sv
// Combinational hex-to-segment decoder with an active decimal point that
// pulls the dp segment low.
module seg7_decode
  import seg7_mux_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] cathode
);

  always_comb begin
    cathode = seg_lookup(nibble);
    if (dp) begin
      cathode[DP_BIT] = 1'b0;
    end
  end

endmodule

// File: rtl/seg7_mux_ctrl.sv
// Time-multiplexed seven-segment driver: slot/digit counters, tear-free
// configuration shadowing, leading-zero blanking, PWM dimming and anti-ghosting.
module seg7_mux_ctrl
  import seg7_mux_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BRIGHT_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    load,
  output logic [7:0]              cathode,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CMP_W = CNT_W + BRIGHT_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CMP_W-1:0] DIV_EXT  = CMP_W'(REFRESH_DIV);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp_en;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    blank_lz;
    logic [BRIGHT_W-1:0]     brightness;
  } cfg_t;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  cfg_t                  pend_q, pend_d;
  cfg_t                  act_q, act_d;
  logic [7:0]            cathode_q, cathode_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  frame_done_q, frame_done_d;

  cfg_t                  cfg_in;
  logic                  slot_end;
  logic                  wrap;
  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic                  cur_en;
  logic [NUM_DIGITS-1:0] zero_above;
  logic                  blank;
  logic [CMP_W-1:0]      pos_scaled;
  logic [CMP_W-1:0]      duty_limit;
  logic                  pwm_on;
  logic                  anode_on;
  logic [7:0]            dec_cathode;

  always_comb begin
    cfg_in            = '0;
    cfg_in.data       = data;
    cfg_in.dp_en      = dp_en;
    cfg_in.digit_en   = digit_en;
    cfg_in.blank_lz   = blank_lz;
    cfg_in.brightness = brightness;
  end

  // The active set only changes at the frame wrap, so a frame never mixes old and new data.
  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    wrap     = slot_end && (idx_q == IDX_LAST);
    cnt_d    = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    pend_d = load ? cfg_in : pend_q;
    act_d  = wrap ? pend_q : act_q;
  end

  // zero_above[i] is set when digit i and every more significant digit are zero.
  always_comb begin
    zero_above = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zero_above[i] = ((act_q.data >> (4 * i)) == '0);
    end
  end

  always_comb begin
    cur_nibble = act_q.data[{idx_q, 2'b00} +: 4];
    cur_dp     = act_q.dp_en[idx_q];
    cur_en     = act_q.digit_en[idx_q];
    blank      = act_q.blank_lz && (idx_q != '0) && zero_above[idx_q];
  end

  seg7_decode u_decode (
    .nibble  (cur_nibble),
    .dp      (cur_dp),
    .cathode (dec_cathode)
  );

  // floor(cnt * 2^BRIGHT_W / REFRESH_DIV) < b is equivalent to cnt * 2^BRIGHT_W < b * REFRESH_DIV.
  always_comb begin
    pos_scaled = CMP_W'({cnt_q, {BRIGHT_W{1'b0}}});
    duty_limit = CMP_W'(act_q.brightness) * DIV_EXT;
    pwm_on     = (&act_q.brightness) || (pos_scaled < duty_limit);
    anode_on   = cur_en && (cnt_q != '0) && pwm_on;
  end

  always_comb begin
    anode_d      = anode_on ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    cathode_d    = blank ? SEG_OFF : dec_cathode;
    frame_done_d = wrap;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      act_q        <= '0;
      cathode_q    <= SEG_OFF;
      anode_q      <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      act_q        <= act_d;
      cathode_q    <= cathode_d;
      anode_q      <= anode_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign cathode    = cathode_q;
  assign anode      = anode_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/seg7_mux_ctrl.md
SEG7_MUX_CTRL -- requirements
Module: seg7_mux_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8, giving the number of multiplexed digits (range 2..16).
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000, giving clk cycles per digit slot (minimum 4).
REQ-003 The block SHALL have parameter BRIGHT_W, default 4, giving the brightness control width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock (100 MHz).
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port data, input, 4*NUM_DIGITS bits: hex nibbles, with digit i at [4i+3:4i].
REQ-007 The block SHALL have port dp_en, input, NUM_DIGITS bits: per-digit decimal point enable.
REQ-008 The block SHALL have port digit_en, input, NUM_DIGITS bits: per-digit enable.
REQ-009 The block SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable.
REQ-010 The block SHALL have port brightness, input, BRIGHT_W bits: PWM duty setting.
REQ-011 The block SHALL have port load, input, 1 bit: single-cycle capture strobe for all the configuration inputs listed in REQ-016.
REQ-012 The block SHALL have port cathode, output, 8 bits: active-low segments, with bit7 = dp and bits 6:0 = g..a.
REQ-013 The block SHALL have port anode, output, NUM_DIGITS bits: active-low digit select.
REQ-014 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at frame wrap.

Function
REQ-015 Slot counter: SHALL count 0..REFRESH_DIV-1; at the terminal count, the digit index SHALL advance, wrapping NUM_DIGITS-1 to 0.
REQ-016 On load=1, data, dp_en, digit_en, blank_lz and brightness SHALL be captured into a pending register.
REQ-017 The pending register SHALL be copied to the active register only on the cycle the index wraps to 0 (tear-free update).
REQ-018 A load coinciding with the wrap cycle SHALL be applied at the following wrap.
REQ-019 Multiple loads within one frame SHALL result in the last one winning.
REQ-020 Digit decode SHALL be: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E (bit7 forced to 0 when dp is active).
REQ-021 Leading-zero blanking: digit i (i>0) SHALL show cathode FF when blank_lz=1 and all nibbles i..NUM_DIGITS-1 are 0.
REQ-022 Digit 0 SHALL never be blanked by leading-zero blanking.
REQ-023 A digit with digit_en[i]=0 SHALL have its anode held high for the whole slot.
REQ-024 Anti-ghosting: cycle 0 of every slot SHALL have all anodes high while the cathode updates.
REQ-025 PWM: phase = the top BRIGHT_W bits of the slot position scaled to 2^BRIGHT_W; the anode SHALL be active when phase < brightness.
REQ-026 brightness = all-ones SHALL force the anode active for the whole slot except cycle 0.
REQ-027 brightness = 0 SHALL force the anode fully off.
REQ-028 cathode and anode SHALL be registered, with 1-cycle latency from the index/phase change.
REQ-029 frame_done SHALL pulse high exactly 1 cycle per frame (every NUM_DIGITS*REFRESH_DIV cycles), regardless of brightness or enables.

Reset
REQ-030 While rst=0, the block SHALL force anode = all ones, cathode = FF and frame_done = 0, asynchronously.
REQ-031 While rst=0, the block SHALL clear the slot counter, digit index, and pending and active registers to 0.
REQ-032 After rst deasserts, the first slot SHALL start at digit 0 with the counter at 0.
REQ-033 Assertion of rst mid-frame SHALL discard any pending load.

Structure
REQ-034 A shared package SHALL hold the 16-entry segment code table and the constants SEG_OFF=8'hFF and the DP bit index 7.
REQ-035 Hex-to-segment decode SHALL be a combinational sub-module seg7_decode (nibble and dp in; 8-bit cathode out).
REQ-036 All other logic (counters, load/shadow registers, blanking, PWM) SHALL reside in seg7_mux_ctrl.

Verification (NUM_DIGITS=8, REFRESH_DIV=16, BRIGHT_W=4)
REQ-037 Bench SHALL cover: load data=32'h01234567, digit_en=FF, brightness=F -> after the next wrap, anode FE/cathode F8, anode FD/cathode 82, ..., anode 7F/cathode C0.
REQ-038 Bench SHALL cover: blank_lz=1, data=32'h000000A5 -> digits 2..7 cathode FF, digit1 cathode 88, digit0 cathode 92; then data=0 -> digit0 cathode C0 with all others FF.
REQ-039 Bench SHALL cover: dp_en=8'h08, nibble3=8 -> cathode 00 during anode F7.
REQ-040 Bench SHALL cover: load during digit 3 -> old data is shown through digit 7, and new data first appears at anode FE.
REQ-041 Bench SHALL cover: brightness=0 -> anode FF throughout, with frame_done pulsing every 128 cycles; brightness=8 -> anode active on slot cycles 1..7 only.
REQ-042 Bench SHALL cover: rst asserted during digit 5 -> anode FF and cathode FF immediately; after release, the first active anode is FE with cathode C0.
